// File: rtl/simmem_resp_release_bank.sv
`default_nettype none
// ============================================================================
// Module      : simmem_resp_release_bank
// Description : Response slot bank for the simulated memory. Stores incoming
//               response payloads in free slots, reports the allocated slot
//               index to the delay bank, and releases slots to a single
//               registered output stage when the delay bank permits it.
// Revision    : 1.0 - initial release
// ============================================================================
module simmem_resp_release_bank #(
    parameter int TotalCapacity = 64,
    parameter int DataWidth     = 32,
    localparam int AddrWidth    = $clog2(TotalCapacity)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    // Response input side
    input  logic [DataWidth-1:0]     in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [AddrWidth-1:0]     local_identifier_o,

    // Release control from the delay bank
    input  logic [TotalCapacity-1:0] release_en_i,
    output logic [TotalCapacity-1:0] address_released_onehot_o,

    // Response output side
    output logic [DataWidth-1:0]     out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [TotalCapacity-1:0] valid_q,    valid_d;
    logic [DataWidth-1:0]     data_q      [TotalCapacity];
    logic [DataWidth-1:0]     data_d      [TotalCapacity];
    logic                     out_valid_q, out_valid_d;
    logic [DataWidth-1:0]     out_data_q,  out_data_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                     w_free_found;
    logic [AddrWidth-1:0]     w_free_idx;
    logic                     w_in_fire;

    logic [TotalCapacity-1:0] w_releasable;
    logic                     w_rel_found;
    logic [AddrWidth-1:0]     w_rel_idx;
    logic                     w_loadable;
    logic                     w_rel_fire;
    logic [TotalCapacity-1:0] w_rel_onehot;

    // Lowest-index free slot; index defaults to 0 when the bank is full.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < TotalCapacity; i++) begin
            if (!w_free_found && !valid_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = AddrWidth'(i);
            end
        end
    end

    assign in_ready_o         = |(~valid_q);
    assign local_identifier_o = w_free_idx;
    assign w_in_fire          = in_valid_i && in_ready_o;

    // A slot whose payload has been moved to the output register already has
    // its valid bit cleared, so masking with valid_q also excludes the slot
    // currently held in the output register. Permission for empty slots is
    // ignored by the same mask.
    assign w_releasable = valid_q & release_en_i;
    assign w_loadable   = !out_valid_q || out_ready_i;

    // Lowest-index releasable slot.
    always_comb begin
        w_rel_found = 1'b0;
        w_rel_idx   = '0;
        for (int i = 0; i < TotalCapacity; i++) begin
            if (!w_rel_found && w_releasable[i]) begin
                w_rel_found = 1'b1;
                w_rel_idx   = AddrWidth'(i);
            end
        end
    end

    assign w_rel_fire = w_loadable && w_rel_found;

    // One-hot pulse naming the slot moved to the output register this cycle.
    always_comb begin
        w_rel_onehot = '0;
        if (w_rel_fire) begin
            w_rel_onehot[w_rel_idx] = 1'b1;
        end
    end

    assign address_released_onehot_o = w_rel_onehot;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------

    // Slot valid bits: set on allocation, cleared on release. Allocation only
    // targets invalid slots and release only valid ones, so the two never hit
    // the same slot in one cycle; a freed slot becomes allocatable next cycle.
    always_comb begin
        valid_d = valid_q;
        if (w_in_fire) begin
            valid_d[w_free_idx] = 1'b1;
        end
        if (w_rel_fire) begin
            valid_d[w_rel_idx] = 1'b0;
        end
    end

    // Slot payloads: written only when a transfer allocates the slot.
    always_comb begin
        data_d = data_q;
        if (w_in_fire) begin
            data_d[w_free_idx] = in_data_i;
        end
    end

    // Output register: load the selected slot whenever the stage can accept,
    // drop valid on a handshake with nothing selected, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (w_loadable) begin
            out_valid_d = w_rel_found;
            if (w_rel_found) begin
                out_data_d = data_q[w_rel_idx];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    // Control state and output stage; reset discards every stored response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Payload storage needs no reset: a slot is only read while its valid
    // bit is set, which implies it was written after reset.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_simmem_resp_release_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_simmem_resp_release_bank
// Description : Directed self-checking bench for simmem_resp_release_bank
//               with a 4-slot, 8-bit configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simmem_resp_release_bank;

    localparam int C_CAP = 4;
    localparam int C_DW  = 8;
    localparam int C_AW  = 2;

    logic              clk_i;
    logic              rst_ni;
    logic [C_DW-1:0]   in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [C_AW-1:0]   local_identifier_o;
    logic [C_CAP-1:0]  release_en_i;
    logic [C_CAP-1:0]  address_released_onehot_o;
    logic [C_DW-1:0]   out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;

    int checks;
    int errors;

    simmem_resp_release_bank #(
        .TotalCapacity (C_CAP),
        .DataWidth     (C_DW)
    ) dut (
        .clk_i                     (clk_i),
        .rst_ni                    (rst_ni),
        .in_data_i                 (in_data_i),
        .in_valid_i                (in_valid_i),
        .in_ready_o                (in_ready_o),
        .local_identifier_o        (local_identifier_o),
        .release_en_i              (release_en_i),
        .address_released_onehot_o (address_released_onehot_o),
        .out_data_o                (out_data_o),
        .out_valid_o               (out_valid_o),
        .out_ready_i               (out_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge; inputs change here and are
    // checked at the following falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        in_data_i    = '0;
        in_valid_i   = 1'b0;
        release_en_i = '0;
        out_ready_i  = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h, expected 0/00", out_valid_o, out_data_o);
        end
        checks++;
        if (in_ready_o !== 1'b1 || local_identifier_o !== 2'd0 || address_released_onehot_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b id=%0d rel=%b, expected 1/0/0000",
                     in_ready_o, local_identifier_o, address_released_onehot_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_release();
        in_valid_i = 1'b1; in_data_i = 8'hA1; release_en_i = 4'b0000; out_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (local_identifier_o !== 2'd0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_alloc: id=%0d ready=%b, expected 0/1", local_identifier_o, in_ready_o);
        end
        tick();
        in_valid_i = 1'b0; release_en_i = 4'b0001;
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b0001 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: rel=%b valid=%b, expected 0001/0", address_released_onehot_o, out_valid_o);
        end
        tick();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hA1 || address_released_onehot_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_out: valid=%b data=%h rel=%b, expected 1/a1/0000",
                     out_valid_o, out_data_o, address_released_onehot_o);
        end
        tick();
        release_en_i = 4'b0000; out_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: valid=%b, expected 0", out_valid_o);
        end
        tick();
    endtask

    task automatic test_release_ignore();
        in_valid_i = 1'b0; release_en_i = 4'b1111; out_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b0000 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_release: rel=%b valid=%b, expected 0000/0", address_released_onehot_o, out_valid_o);
        end
        tick();
        in_valid_i = 1'b1; in_data_i = 8'h55;
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b0000) begin
            errors++;
            $display("FAIL ignore_store_cycle: rel=%b, expected 0000", address_released_onehot_o);
        end
        tick();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b0001) begin
            errors++;
            $display("FAIL ignore_pulse: rel=%b, expected 0001", address_released_onehot_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'h55 || address_released_onehot_o !== 4'b0000) begin
            errors++;
            $display("FAIL ignore_out: valid=%b data=%h rel=%b, expected 1/55/0000",
                     out_valid_o, out_data_o, address_released_onehot_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || address_released_onehot_o !== 4'b0000) begin
            errors++;
            $display("FAIL ignore_single: valid=%b rel=%b, expected 0/0000", out_valid_o, address_released_onehot_o);
        end
        release_en_i = 4'b0000; out_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_full();
        logic [7:0] exp_data [3];
        logic [3:0] exp_rel  [3];
        exp_data = '{8'h10, 8'h11, 8'h13};
        exp_rel  = '{4'b0010, 4'b1000, 4'b0000};
        release_en_i = 4'b0000; out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'h10 + 8'(i);
            @(negedge clk_i);
            checks++;
            if (local_identifier_o !== 2'(i) || in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL fill_id%0d: id=%0d ready=%b, expected %0d/1", i, local_identifier_o, in_ready_o, i);
            end
            tick();
        end
        in_valid_i = 1'b1; in_data_i = 8'hEE;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b0 || local_identifier_o !== 2'd0) begin
            errors++;
            $display("FAIL full_state: ready=%b id=%0d, expected 0/0", in_ready_o, local_identifier_o);
        end
        tick();
        in_valid_i = 1'b0; release_en_i = 4'b0100; out_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b0100 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_release: rel=%b ready=%b, expected 0100/0", address_released_onehot_o, in_ready_o);
        end
        tick();
        release_en_i = 4'b0000;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1 || local_identifier_o !== 2'd2 || out_valid_o !== 1'b1 || out_data_o !== 8'h12) begin
            errors++;
            $display("FAIL full_freed: ready=%b id=%0d valid=%b data=%h, expected 1/2/1/12",
                     in_ready_o, local_identifier_o, out_valid_o, out_data_o);
        end
        tick();
        release_en_i = 4'b1011;
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b0001 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_first: rel=%b valid=%b, expected 0001/0", address_released_onehot_o, out_valid_o);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_data[i] || address_released_onehot_o !== exp_rel[i]) begin
                errors++;
                $display("FAIL drain%0d: valid=%b data=%h rel=%b, expected 1/%h/%b",
                         i, out_valid_o, out_data_o, address_released_onehot_o, exp_data[i], exp_rel[i]);
            end
            tick();
        end
        release_en_i = 4'b0000;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: valid=%b ready=%b, expected 0/1", out_valid_o, in_ready_o);
        end
        out_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        release_en_i = 4'b0000; out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'h20 + 8'(i);
            tick();
        end
        in_valid_i = 1'b0; release_en_i = 4'b0101;
        tick();
        tick();
        tick();
        release_en_i = 4'b0000;
        tick();
        release_en_i = 4'b1010;
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b0010 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: rel=%b valid=%b, expected 0010/0", address_released_onehot_o, out_valid_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b1000 || out_valid_o !== 1'b1 || out_data_o !== 8'h21) begin
            errors++;
            $display("FAIL b2b_second: rel=%b valid=%b data=%h, expected 1000/1/21",
                     address_released_onehot_o, out_valid_o, out_data_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'h23 || address_released_onehot_o !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_nobubble: valid=%b data=%h rel=%b, expected 1/23/0000",
                     out_valid_o, out_data_o, address_released_onehot_o);
        end
        tick();
        release_en_i = 4'b0000; out_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b, expected 0", out_valid_o);
        end
        tick();
    endtask

    task automatic test_stall();
        release_en_i = 4'b0000; out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_data_i = 8'h30 + 8'(i);
            tick();
        end
        in_valid_i = 1'b0; release_en_i = 4'b0001;
        tick();
        release_en_i = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 8'h30 || address_released_onehot_o !== 4'b0000) begin
                errors++;
                $display("FAIL stall%0d: valid=%b data=%h rel=%b, expected 1/30/0000",
                         i, out_valid_o, out_data_o, address_released_onehot_o);
            end
            tick();
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (address_released_onehot_o !== 4'b0100) begin
            errors++;
            $display("FAIL stall_accept: rel=%b, expected 0100", address_released_onehot_o);
        end
        tick();
        out_ready_i = 1'b0; release_en_i = 4'b0000;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'h32) begin
            errors++;
            $display("FAIL stall_next: valid=%b data=%h, expected 1/32", out_valid_o, out_data_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // Slot 1 is still valid and the output holds 0x32 on entry.
        in_valid_i = 1'b1; in_data_i = 8'h40;
        @(negedge clk_i);
        checks++;
        if (local_identifier_o !== 2'd0) begin
            errors++;
            $display("FAIL mid_alloc0: id=%0d, expected 0", local_identifier_o);
        end
        tick();
        in_data_i = 8'h41;
        @(negedge clk_i);
        checks++;
        if (local_identifier_o !== 2'd2) begin
            errors++;
            $display("FAIL mid_alloc2: id=%0d, expected 2", local_identifier_o);
        end
        tick();
        in_valid_i = 1'b0; release_en_i = 4'b1111; rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== 8'h00 || address_released_onehot_o !== 4'b0000 ||
            in_ready_o !== 1'b1 || local_identifier_o !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b data=%h rel=%b ready=%b id=%0d, expected 0/00/0000/1/0",
                     out_valid_o, out_data_o, address_released_onehot_o, in_ready_o, local_identifier_o);
        end
        tick();
        rst_ni = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (out_valid_o !== 1'b0 || address_released_onehot_o !== 4'b0000) begin
                errors++;
                $display("FAIL mid_stale%0d: valid=%b rel=%b, expected 0/0000", i, out_valid_o, address_released_onehot_o);
            end
            tick();
        end
        release_en_i = 4'b0000; out_ready_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_release();
        test_release_ignore();
        test_full();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simmem_resp_release_bank.md
SIMMEM_RESP_RELEASE_BANK -- requirements
Module: simmem_resp_release_bank

Interface
- REQ-001: Parameter TotalCapacity, default 64, is the number of response slots; power of two, at least 2.
- REQ-002: Parameter DataWidth, default 32, is the response payload width in bits.
- REQ-003: Localparam AddrWidth SHALL equal $clog2(TotalCapacity).
- REQ-004: clk_i  input  1  clock; all state updates on rising edge.
- REQ-005: rst_ni  input  1  asynchronous, active-low reset.
- REQ-006: in_data_i  input  DataWidth  response payload to store.
- REQ-007: in_valid_i  input  1  producer offers in_data_i.
- REQ-008: in_ready_o  output  1  a free slot exists.
- REQ-009: local_identifier_o  output  AddrWidth  slot index that the current input transfer occupies; forwarded to the delay bank.
- REQ-010: release_en_i  input  TotalCapacity  per-slot release permission from the delay bank.
- REQ-011: address_released_onehot_o  output  TotalCapacity  one-hot pulse naming the slot emitted this cycle.
- REQ-012: out_data_o  output  DataWidth  released payload.
- REQ-013: out_valid_o  output  1  out_data_o holds a released payload.
- REQ-014: out_ready_i  input  1  consumer accepts out_data_o.

Function
- REQ-015: Each slot SHALL hold a registered valid bit and a DataWidth payload.
- REQ-016: in_ready_o SHALL be the OR of the inverted registered valid bits; it is combinational from state only and independent of in_valid_i.
- REQ-017: local_identifier_o SHALL be the lowest-index invalid slot; when full, it SHALL be 0.
- REQ-018: An input transfer occurs when in_valid_i && in_ready_o; the payload and valid bit are written to slot local_identifier_o at the next edge.
- REQ-019: A slot is releasable when its valid bit && release_en_i[slot] && it is not already in the output register.
- REQ-020: The output register is loadable when !out_valid_o || out_ready_i.
- REQ-021: When the register is loadable and any slot is releasable, the lowest-index releasable slot SHALL be selected. Its payload is loaded into the output register at the next edge, and its valid bit is cleared at that same edge.
- REQ-022: address_released_onehot_o SHALL be the combinational one-hot of the slot selected in REQ-021, or all-zero when none is selected; it asserts in the same cycle as the selection.
- REQ-023: Latency: release_en_i first seen high in cycle t, with the register loadable, gives out_valid_o high in cycle t+1; the minimum store-to-output time is 2 cycles.
- REQ-024: out_valid_o SHALL stay high and out_data_o SHALL stay stable until out_ready_i is sampled high.
- REQ-025: On output handshake with no slot selected, out_valid_o SHALL fall at the next edge.
- REQ-026: Output handshake and a new selection in the same cycle give back-to-back output with no bubble.
- REQ-027: A slot freed at edge e SHALL first be allocatable in the cycle after e; allocation never uses a slot being freed in the same cycle.
- REQ-028: release_en_i bits for invalid slots SHALL be ignored.
- REQ-029: Full bank (in_ready_o=0): in_valid_i is ignored and no state changes on the input side.
- REQ-030: Empty bank: out_valid_o and address_released_onehot_o stay 0 whatever release_en_i is.

Reset
- REQ-031: While rst_ni=0, all slot valid bits, out_valid_o and out_data_o SHALL be 0.
- REQ-032: After reset, in_ready_o=1, local_identifier_o=0 and address_released_onehot_o=0.
- REQ-033: Reset asserted mid-operation SHALL discard all stored and pending responses, with no released pulse.

Verification (TotalCapacity=4, DataWidth=8)
- REQ-034: Store 0xA1 (slot 0), hold release_en_i=0001 from the next cycle -> released=0001 for one cycle, out_valid_o=1 with 0xA1 one cycle later.
- REQ-035: Fill 4 entries with no release -> in_ready_o=0, local_identifier_o=0; a 5th in_valid_i is dropped. Release slot 2 -> in_ready_o=1 with local_identifier_o=2 the cycle after the released pulse.
- REQ-036: Slots 1 and 3 stored, release_en_i=1010 in one cycle -> slot 1 emitted first, slot 3 next cycle, out_ready_i held 1 with no bubble.
- REQ-037: out_ready_i=0 for 3 cycles with out_valid_o=1 and slot 2 releasable -> out_data_o stable, released=0000 throughout; out_ready_i=1 -> released=0100 in that cycle.
- REQ-038: release_en_i=1111 with only slot 0 valid -> exactly one output, and no pulses for slots 1-3.
- REQ-039: rst_ni pulsed low while 3 slots are valid and out_valid_o=1 -> all outputs at reset values; no stale data emitted afterwards.
